// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequential ALU controller. It latches a command on a start
//               strobe, then either evaluates a bitwise operation in one
//               EXEC cycle or performs a shift one bit per cycle in SHIFT.
//               A DONE cycle follows, marked by a one-cycle done pulse.
//               result, zero and err are registered and hold their values
//               between completions.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         err
);

    // Opcode encoding
    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_XOR = 3'b010;
    localparam logic [2:0] c_OP_SHR = 3'b011;
    localparam logic [2:0] c_OP_SHL = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;

    // State encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_EXEC  = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // The shift counter must be able to hold the value N itself, because
    // oversized shift amounts saturate at N.
    localparam int          c_CNT_W = $clog2(N + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(N);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_work;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [N-1:0]       r_result;
    logic               r_zero;
    logic               r_err;

    logic [N-1:0]       w_logic_res;
    logic               w_logic_err;
    logic [c_CNT_W-1:0] w_shift_amt;
    logic               w_is_shift;

    // Clamp the requested shift amount to N so that oversized amounts clear the word
    always_comb begin
        w_shift_amt = c_CNT_MAX;
        if (32'(b) < N) begin
            w_shift_amt = c_CNT_W'(b);
        end
    end

    assign w_is_shift = (op == c_OP_SHR) || (op == c_OP_SHL);

    // Single-cycle operations evaluated on the latched operands
    always_comb begin
        w_logic_res = '0;
        w_logic_err = 1'b0;
        case (r_op)
            c_OP_AND: w_logic_res = r_a & r_b;
            c_OP_OR:  w_logic_res = r_a | r_b;
            c_OP_XOR: w_logic_res = r_a ^ r_b;
            c_OP_NOT: w_logic_res = ~r_a;
            default: begin
                // Shift opcodes never reach EXEC; anything else is invalid
                w_logic_res = '0;
                w_logic_err = 1'b1;
            end
        endcase
    end

    // Control FSM with registered outputs; reset aborts any command in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Snapshot the command so later input changes cannot disturb it
                        r_op   <= op;
                        r_a    <= a;
                        r_b    <= b;
                        r_work <= a;
                        r_cnt  <= w_shift_amt;
                        r_busy <= 1'b1;
                        r_state <= w_is_shift ? c_ST_SHIFT : c_ST_EXEC;
                    end
                end

                c_ST_EXEC: begin
                    r_result <= w_logic_res;
                    r_zero   <= (w_logic_res == '0);
                    r_err    <= w_logic_err;
                    r_done   <= 1'b1;
                    r_state  <= c_ST_DONE;
                end

                c_ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        // One bit per cycle, zero-filled from the vacated end
                        if (r_op == c_OP_SHR) begin
                            r_work <= r_work >> 1;
                        end else begin
                            r_work <= r_work << 1;
                        end
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_result <= r_work;
                        r_zero   <= (r_work == '0);
                        r_err    <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end
                end

                default: begin
                    // DONE: single-cycle pulse, start is ignored here
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Self-checking bench for alu_seq_ctrl: directed commands
//               followed by random commands compared against an arithmetic
//               reference model, plus busy rejection and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         zero;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] last_res = '0;

    alu_seq_ctrl #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain arithmetic on the opcode table
    function automatic logic [N-1:0] model_res(input logic [2:0] m_op, input logic [N-1:0] m_a,
                                               input logic [N-1:0] m_b);
        int ia;
        int ib;
        int r;
        ia = int'(m_a);
        ib = int'(m_b);
        case (m_op)
            3'd0:    r = ia & ib;
            3'd1:    r = ia | ib;
            3'd2:    r = ia ^ ib;
            3'd3:    r = ia >> ib;
            3'd4:    r = (ia << ib) & MASK;
            3'd5:    r = (~ia) & MASK;
            default: r = 0;
        endcase
        return N'(r);
    endfunction

    function automatic int model_lat(input logic [2:0] m_op, input logic [N-1:0] m_b);
        int amt;
        amt = (int'(m_b) < N) ? int'(m_b) : N;
        if (m_op == 3'd3 || m_op == 3'd4) return 2 + amt;
        return 2;
    endfunction

    // Issue one command and follow it to completion; optionally keep start
    // asserted with a different opcode during the whole busy period.
    task automatic run_cmd(input logic [2:0] t_op, input logic [N-1:0] t_a,
                           input logic [N-1:0] t_b, input bit hammer);
        logic [N-1:0] exp_res;
        int exp_lat;
        int lat;
        exp_res = model_res(t_op, t_a, t_b);
        exp_lat = model_lat(t_op, t_b);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(posedge clk); #1;
        // Scramble the inputs: the command in flight must not notice
        start = hammer;
        op    = hammer ? 3'b001 : 3'($urandom);
        a     = N'($urandom);
        b     = N'($urandom);
        lat   = 0;
        for (int cyc = 1; cyc <= N + 6 && lat == 0; cyc++) begin
            if (done === 1'b1) begin
                lat = cyc;
            end else begin
                check("busy_in_flight", 32'(busy), 32'd1);
                if (cyc == 1) check("result_held", 32'(result), 32'(last_res));
                @(posedge clk); #1;
            end
        end
        check("latency", lat, exp_lat);
        if (lat != 0) begin
            check("result", 32'(result), 32'(exp_res));
            check("zero", 32'(zero), 32'(exp_res == '0));
            check("err", 32'(err), 32'(t_op > 3'd5));
            check("busy_at_done", 32'(busy), 32'd1);
            last_res = exp_res;
            @(posedge clk); #1;
            start = 1'b0;
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
            @(posedge clk); #1;
            check("no_queued_cmd", 32'(busy | done), 32'd0);
            check("result_hold", 32'(result), 32'(exp_res));
        end
        start = 1'b0;
    endtask

    initial begin
        bit seen_done;
        // Reset state, observed before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Bitwise ops on 1100 / 1010
        run_cmd(3'b000, 4'b1100, 4'b1010, 1'b0);
        run_cmd(3'b001, 4'b1100, 4'b1010, 1'b0);
        run_cmd(3'b010, 4'b1100, 4'b1010, 1'b0);
        run_cmd(3'b101, 4'b1100, 4'b1010, 1'b0);
        // Shifts: normal, saturated, zero amount
        run_cmd(3'b100, 4'b0011, 4'd2, 1'b0);
        run_cmd(3'b011, 4'b1000, 4'd7, 1'b0);
        run_cmd(3'b011, 4'b1011, 4'd0, 1'b0);
        run_cmd(3'b100, 4'b1011, 4'd4, 1'b0);
        // start held high through the whole command
        run_cmd(3'b000, 4'b1100, 4'b1010, 1'b1);
        run_cmd(3'b100, 4'b0101, 4'd3, 1'b1);
        // Invalid opcode then a valid one clears err
        run_cmd(3'b110, 4'b1111, 4'b0101, 1'b0);
        run_cmd(3'b001, 4'b0000, 4'b0010, 1'b0);
        run_cmd(3'b111, 4'b1010, 4'b1111, 1'b0);

        // Async reset in the middle of a shift
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 4'b0001; b = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        check("arst_no_done", 32'(seen_done), 32'd0);
        // First command after reset is accepted normally
        run_cmd(3'b010, 4'b0110, 4'b0011, 1'b0);

        // Random commands against the model
        for (int k = 0; k < 40; k++) begin
            run_cmd(3'($urandom_range(0, 7)), N'($urandom), N'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter N, default 4, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  command strobe; sampled only when busy=0.
REQ-005 op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 SHR, 100 SHL, 101 NOT, 110/111 invalid.
REQ-006 a  input  N  operand A, the data operand for shifts and NOT.
REQ-007 b  input  N  operand B for AND/OR/XOR; unsigned shift amount for SHR/SHL; ignored for NOT.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 result  output  N  registered result of last completed command.
REQ-011 zero  output  1  high when result is all zeros.
REQ-012 err  output  1  high when the last completed command had an invalid opcode.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, SHIFT and DONE.
REQ-014 In IDLE, a rising edge with start=1 SHALL latch op, a and b into internal registers.
- SHR/SHL go to SHIFT.
- All other opcodes go to EXEC.
REQ-015 On entry to SHIFT, the shift counter SHALL load min(b, N) and the working register SHALL load a.
REQ-016 In EXEC, the next edge SHALL register the op result into result and go to DONE.
- AND/OR/XOR/NOT are bitwise on the latched operands.
- NOT ignores b.
- An invalid opcode gives result=0 and err=1.
REQ-017 In SHIFT, each edge with counter>0 SHALL shift the working register by one bit, zero-filling, and decrement the counter.
- SHR moves bit i+1 into bit i, with MSB filled 0.
- SHL moves bit i-1 into bit i, with LSB filled 0.
REQ-018 In SHIFT, an edge with counter=0 SHALL copy the working register to result and go to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-020 Latency, counted from the edge sampling start to the first cycle with done=1:
- 2 cycles for logic, NOT and invalid ops.
- 2+min(b,N) cycles for shifts; a shift amount of 0 takes 2 cycles and returns a unchanged.
REQ-021 start SHALL be ignored while busy=1, including the DONE cycle, with no queuing.
REQ-022 result, zero and err SHALL update only on the edge entering DONE, and hold until the next completion.
REQ-023 zero SHALL equal (result==0); err SHALL be cleared on every valid-op completion.
REQ-024 Input changes on a, b or op after the start edge SHALL NOT affect the command in flight.
REQ-025 Shift amounts b>=N SHALL yield result 0 after N shift cycles.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE and set the outputs and internal registers as follows:
- busy=0, done=0.
- result=0, zero=1, err=0.
- Shift counter and working register cleared.
REQ-027 Reset asserted mid-command SHALL abort the command, with no done pulse and result not updated.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 Logic op: N=4, op=000, a=1100, b=1010, start pulse -> done 2 cycles later, result=1000, zero=0, err=0; repeat OR -> 1110, XOR -> 0110, NOT -> 0011.
REQ-030 Left shift: op=100, a=0011, b=2 -> busy for 4 cycles, done at latency 4, result=1100.
REQ-031 Saturated right shift: op=011, a=1000, b=7 -> done at latency 6, result=0000, zero=1.
REQ-032 Busy rejection: start op=000 then start op=001 on the next 3 cycles and in the DONE cycle -> only one done pulse, result from the first command.
REQ-033 Async reset mid-shift: start SHL with a=0001, b=3, assert rst during SHIFT between clock edges -> busy=0 and result=0 immediately, and no done pulse appears.
REQ-034 Invalid op: op=110, a=1111 -> done at latency 2, result=0000, err=1, zero=1; a following valid op clears err.
